// File: rtl/dca_matrix_row_packer.sv
// dca_matrix_row_packer
//
// Upstream feeder for the DCA matrix register. Scalars arrive over a
// valid/ready stream and are packed MATRIX_SIZE_PARA at a time into one
// tensor row. Each completed row is pushed with a single-cycle
// move_wenable strobe. After MATRIX_SIZE_PARA rows the block pulses done.
//
// Optional feature macro: DCA_ROW_PACKER_TRANSPOSE_EN
//   defined   : transpose pulses together with done. This turns the
//               column-major input stream into row-major register content.
//   undefined : transpose is tied to 0. The port is kept so the interface
//               stays the same in both builds.
//
// Ports:
//   clk              clock, rising edge
//   rstpp            asynchronous active-high reset
//   start            begin loading one matrix (honoured only when idle)
//   abort            drop the current load and return to idle (highest priority)
//   s_valid/s_ready  scalar stream handshake
//   s_data           scalar payload
//   move_wenable     one-cycle row push strobe
//   move_wdata_list  registered packed row; lane k at [k*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR]
//   busy             high while a load is in progress (FILL, PUSH, DONE)
//   done             one-cycle pulse after the last row push
//   transpose        transpose request to the matrix register

module dca_matrix_row_packer #(
    parameter int unsigned MATRIX_SIZE_PARA = 8,
    parameter int unsigned BW_TENSOR_SCALAR = 32,
    parameter int unsigned BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR
) (
    input  logic                        clk,
    input  logic                        rstpp,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [BW_TENSOR_SCALAR-1:0] s_data,
    output logic                        move_wenable,
    output logic [BW_TENSOR_ROW-1:0]    move_wdata_list,
    output logic                        busy,
    output logic                        done,
    output logic                        transpose
);

    localparam int unsigned CntW = $clog2(MATRIX_SIZE_PARA);
    localparam logic [CntW-1:0] LastIdx = CntW'(MATRIX_SIZE_PARA - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StPush = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [CntW-1:0]          col_cnt_q, col_cnt_d;
    logic [CntW-1:0]          row_cnt_q, row_cnt_d;
    logic [BW_TENSOR_ROW-1:0] row_buf_q, row_buf_d;
    logic [BW_TENSOR_ROW-1:0] wdata_q, wdata_d;
    logic                     xfer;
    logic                     done_int;

    // abort masks the handshake so a scalar offered in that cycle is not consumed.
    assign s_ready      = (state_q == StFill) && !abort;
    assign xfer         = s_valid && s_ready;
    assign move_wenable = (state_q == StPush) && !abort;
    assign done_int     = (state_q == StDone) && !abort;
    assign done         = done_int;
    assign busy         = (state_q != StIdle);
    assign move_wdata_list = wdata_q;

`ifdef DCA_ROW_PACKER_TRANSPOSE_EN
    assign transpose = done_int;
`else
    assign transpose = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        row_buf_d = row_buf_q;
        wdata_d   = wdata_q;

        // Lane write: first accepted scalar of a row lands in lane 0 (LSBs).
        if (xfer) begin
            for (int k = 0; k < int'(MATRIX_SIZE_PARA); k++) begin
                if (col_cnt_q == CntW'(k)) begin
                    row_buf_d[k*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = s_data;
                end
            end
        end

        if (abort) begin
            state_d   = StIdle;
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StFill;
                        col_cnt_d = '0;
                        row_cnt_d = '0;
                    end
                end
                StFill: begin
                    if (xfer) begin
                        if (col_cnt_q == LastIdx) begin
                            col_cnt_d = '0;
                            state_d   = StPush;
                            // Output row is captured here so it is stable during PUSH.
                            wdata_d   = row_buf_d;
                        end else begin
                            col_cnt_d = col_cnt_q + 1'b1;
                        end
                    end
                end
                StPush: begin
                    if (row_cnt_q == LastIdx) begin
                        row_cnt_d = '0;
                        state_d   = StDone;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                        state_d   = StFill;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            state_q   <= StIdle;
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            row_buf_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            row_buf_q <= row_buf_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_packer.sv
// Directed bench for dca_matrix_row_packer with N=4, 8-bit scalars.
// Expected transpose behaviour follows DCA_ROW_PACKER_TRANSPOSE_EN.

module tb_dca_matrix_row_packer;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned RW = N * BW;

`ifdef DCA_ROW_PACKER_TRANSPOSE_EN
    localparam bit TR_EN = 1'b1;
`else
    localparam bit TR_EN = 1'b0;
`endif

    logic          clk;
    logic          rstpp;
    logic          start;
    logic          abort;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          move_wenable;
    logic [RW-1:0] move_wdata_list;
    logic          busy;
    logic          done;
    logic          transpose;

    int vectors;
    int miscompares;

    dca_matrix_row_packer #(
        .MATRIX_SIZE_PARA(N),
        .BW_TENSOR_SCALAR(BW)
    ) dut (
        .clk             (clk),
        .rstpp           (rstpp),
        .start           (start),
        .abort           (abort),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .move_wenable    (move_wenable),
        .move_wdata_list (move_wdata_list),
        .busy            (busy),
        .done            (done),
        .transpose       (transpose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rstpp = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({s_ready, move_wenable, busy, done, transpose} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {s_ready, move_wenable, busy, done, transpose});
        end
        vectors++;
        if (move_wdata_list !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wdata: got %h want 00000000", move_wdata_list);
        end
        @(posedge clk); #1;
        rstpp = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy got %b want 0", busy);
        end
        @(posedge clk); #1;
    endtask

    // Full-rate load of 0x00..0x0F. With poke_start, start is raised mid-FILL
    // of row 2 and must be ignored.
    task automatic test_full_rate(input bit poke_start);
        logic [31:0] rows [4];
        int acc, push, ndone, done_cyc, last_acc;
        rows[0] = 32'h03020100; rows[1] = 32'h07060504;
        rows[2] = 32'h0B0A0908; rows[3] = 32'h0F0E0D0C;
        acc = 0; push = 0; ndone = 0; done_cyc = 0; last_acc = -10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 8'h00;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (cyc <= 21)) begin
                miscompares++;
                $display("FAIL full_busy c%0d: got %b want %b", cyc, busy, (cyc <= 21));
            end
            vectors++;
            if (transpose !== (TR_EN && cyc == 21)) begin
                miscompares++;
                $display("FAIL full_transpose c%0d: got %b want %b", cyc, transpose,
                         (TR_EN && cyc == 21));
            end
            if (move_wenable) begin
                vectors++;
                if (push > 3 || move_wdata_list !== rows[push & 3]) begin
                    miscompares++;
                    $display("FAIL full_row%0d: got %h want %h", push, move_wdata_list,
                             rows[push & 3]);
                end
                vectors++;
                if (last_acc != cyc - 1 || s_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_push_timing c%0d: last accept c%0d s_ready %b, want c%0d 0",
                             cyc, last_acc, s_ready, cyc - 1);
                end
                push++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (s_valid && s_ready) begin
                acc++;
                last_acc = cyc;
            end
            @(posedge clk); #1;
            s_data  = 8'(acc);
            s_valid = (acc < 16);
            start   = poke_start && (cyc + 1 == 7);
        end
        s_valid = 1'b0;
        vectors++;
        if (push != 4 || acc != 16 || ndone != 1) begin
            miscompares++;
            $display("FAIL full_counts: pushes %0d accepts %0d dones %0d, want 4 16 1",
                     push, acc, ndone);
        end
        vectors++;
        if (done_cyc != 21) begin
            miscompares++;
            $display("FAIL full_latency: done at cycle %0d want 21", done_cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rows [4];
        int acc, push, ndone;
        rows[0] = 32'h13121110; rows[1] = 32'h17161514;
        rows[2] = 32'h1B1A1918; rows[3] = 32'h1F1E1D1C;
        acc = 0; push = 0; ndone = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 8'h10;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (move_wenable) begin
                vectors++;
                if (push > 3 || move_wdata_list !== rows[push & 3]) begin
                    miscompares++;
                    $display("FAIL gap_row%0d: got %h want %h", push, move_wdata_list,
                             rows[push & 3]);
                end
                vectors++;
                if (s_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_ready_in_push: got %b want 0", s_ready);
                end
                push++;
            end
            if (done) ndone++;
            if (s_valid && s_ready) acc++;
            @(posedge clk); #1;
            s_data  = 8'(8'h10 + acc);
            s_valid = (acc < 16) && !s_valid;
        end
        s_valid = 1'b0;
        vectors++;
        if (push != 4 || acc != 16 || ndone != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_counts: pushes %0d accepts %0d dones %0d busy %b, want 4 16 1 0",
                     push, acc, ndone, busy);
        end
    endtask

    task automatic test_abort();
        int acc, push, abort_cyc;
        acc = 0; push = 0; abort_cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 8'h40;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                vectors++;
                if (s_ready !== 1'b0 || move_wenable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL abort_cycle: s_ready %b wenable %b want 0 0",
                             s_ready, move_wenable);
                end
            end else if (abort_cyc != 0 && cyc > abort_cyc) begin
                vectors++;
                if ({busy, move_wenable, done, s_ready, transpose} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL after_abort c%0d: busy/wen/done/rdy/tr got %b want 00000",
                             cyc, {busy, move_wenable, done, s_ready, transpose});
                end
            end
            if (move_wenable) push++;
            if (s_valid && s_ready) acc++;
            @(posedge clk); #1;
            abort = (abort_cyc == 0 && push == 2);
            if (abort) abort_cyc = cyc + 1;
            s_data = 8'(8'h40 + acc);
        end
        s_valid = 1'b0;
        vectors++;
        if (abort_cyc != 11 || acc != 8) begin
            miscompares++;
            $display("FAIL abort_point: abort cycle %0d accepts %0d, want 11 8", abort_cyc, acc);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_same: s_ready %b busy %b want 0 0", s_ready, busy);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_idle: busy %b s_ready %b want 0 0", busy, s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fill();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = 8'hAA;
        @(posedge clk); #1;
        s_data = 8'hBB;
        @(posedge clk); #1;
        s_data = 8'hCC;
        #1;
        rstpp = 1'b1;
        #1;
        vectors++;
        if ({s_ready, move_wenable, busy, done, transpose} !== 5'b0 ||
            move_wdata_list !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: rdy/wen/busy/done/tr %b wdata %h want 00000 00000000",
                     {s_ready, move_wenable, busy, done, transpose}, move_wdata_list);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rstpp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (move_wenable !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_quiet: wenable %b busy %b want 0 0",
                         move_wenable, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_full_rate(1'b0);
        test_reset_mid_fill();
        test_full_rate(1'b0);
        test_backpressure();
        test_abort();
        test_full_rate(1'b0);
        test_start_abort_idle();
        test_full_rate(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
